// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO with tlast sideband, first-word-fall-through output,
// exact fill level, almost-full/almost-empty flags and a synchronous flush.
module axis_sync_fifo #(
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          almost_full,
  output logic                          almost_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  // Handshake: a word moves on either side only in a cycle where valid and ready
  // are both high at the rising edge; ready/valid never look at the other side.
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic          mem_we;

  always_comb begin
    s_axis_tready = (count_q != DEPTH_C);
    m_axis_tvalid = (count_q != '0);
    push          = s_axis_tvalid & s_axis_tready;
    pop           = m_axis_tvalid & m_axis_tready;
    mem_we        = push & ~flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Flush wins over any same-cycle push or pop.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
  end

  always_comb begin
    {m_axis_tlast, m_axis_tdata} = mem_q[rd_ptr_q];
    level        = count_q;
    almost_full  = (count_q >= AFULL_C);
    almost_empty = (count_q <= AEMPTY_C);
  end

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed bench for axis_sync_fifo: a reference count plus an expected-data queue
// track every accepted word and check it when it reaches the head of the FIFO.
module tb_axis_sync_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          arstn;
  logic          flush;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [4:0]    level;
  logic          almost_full;
  logic          almost_empty;

  logic [DW:0] exp_q[$];
  int          mdl_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  axis_sync_fifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut (
    .clk(clk), .arstn(arstn), .flush(flush),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Status outputs against the reference count, plus the head word when one exists.
  task automatic check_status(input string tag);
    chk({tag, " level"}, 32'(level), 32'(mdl_cnt));
    chk({tag, " s_tready"}, 32'(s_tready), 32'(mdl_cnt != DEPTH));
    chk({tag, " m_tvalid"}, 32'(m_tvalid), 32'(mdl_cnt != 0));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(mdl_cnt >= AF));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(mdl_cnt <= AE));
    if (mdl_cnt != 0 && exp_q.size() != 0) begin
      chk({tag, " m_tdata"}, 32'(m_tdata), 32'(exp_q[0][DW-1:0]));
      chk({tag, " m_tlast"}, 32'(m_tlast), 32'(exp_q[0][DW]));
    end
  endtask

  // One clock: check with inputs settled, then advance the model across the edge.
  task automatic cycle(input string tag);
    bit push, pop;
    #1;
    check_status(tag);
    push = s_tvalid && (mdl_cnt != DEPTH);
    pop  = m_tready && (mdl_cnt != 0);
    @(posedge clk);
    #1;
    if (flush) begin
      exp_q.delete();
      mdl_cnt = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back({s_tlast, s_tdata});
      mdl_cnt = mdl_cnt + int'(push) - int'(pop);
    end
  endtask

  task automatic push_words(input int n, input int base, input logic rdy, input string tag);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = (base < 0) ? DW'($urandom_range(0, 16'hFFFF)) : DW'(base + i);
      s_tlast  = (base < 0) ? 1'($urandom_range(0, 1)) : 1'(i == n - 1);
      m_tready = rdy;
      cycle(tag);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b0;
  endtask

  task automatic drain(input string tag);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 2 * DEPTH && mdl_cnt != 0; i++) cycle(tag);
    cycle({tag, " empty"});
    m_tready = 1'b0;
  endtask

  initial begin
    arstn = 1'b0; flush = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    s_tvalid = 1'b0; m_tready = 1'b0;
    #12;
    check_status("reset");
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;

    // Fill with 0x0001..0x0010 while stalled, then offer a 17th word.
    push_words(DEPTH, 1, 1'b0, "fill");
    s_tvalid = 1'b1; s_tdata = 16'h0011; s_tlast = 1'b0;
    cycle("full_offer");
    s_tvalid = 1'b0;
    cycle("full_hold");

    drain("drain");

    // 40 words streamed through: pointers wrap more than twice.
    push_words(40, 16'h0100, 1'b1, "stream");
    drain("stream_drain");

    // Steady state at level 8 with simultaneous push and pop.
    push_words(8, -1, 1'b0, "pre8");
    push_words(20, 16'h0200, 1'b1, "both8");
    drain("both8_drain");

    // Full plus pop: the pop happens, the push does not.
    push_words(DEPTH, -1, 1'b0, "refill");
    s_tvalid = 1'b1; s_tdata = 16'h0333; s_tlast = 1'b1; m_tready = 1'b1;
    cycle("full_pop");
    s_tvalid = 1'b0; m_tready = 1'b0;
    cycle("after_full_pop");
    drain("full_pop_drain");

    // Empty-FIFO latency, tlast and stability under stall.
    s_tvalid = 1'b1; s_tdata = 16'hABCD; s_tlast = 1'b1;
    cycle("latency_push");
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 16'h5555;
    for (int i = 0; i < 5; i++) cycle("stall");
    drain("latency_drain");

    // Flush at level 10 with a push offered.
    push_words(10, -1, 1'b0, "pre_flush");
    flush = 1'b1; s_tvalid = 1'b1; s_tdata = 16'h7777;
    cycle("flush");
    flush = 1'b0; s_tvalid = 1'b0;
    cycle("post_flush");

    // Asynchronous reset mid-cycle at level 5.
    push_words(5, 16'h0400, 1'b0, "pre_rst");
    #3;
    arstn = 1'b0;
    #1;
    exp_q.delete();
    mdl_cnt = 0;
    check_status("async_rst");
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;
    cycle("post_rst");
    push_words(3, 16'h0500, 1'b0, "post_rst_push");
    drain("post_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
